// File: rtl/audio_mixer_if.sv
// Sample-request and mixed-output bundle of the three-channel audio mixer.
// The master side supplies source samples and gains; the slave side is the mixer.
interface audio_mixer_if;
  logic        iSAMPLE_EN;
  logic [7:0]  iCH0;
  logic [7:0]  iCH1;
  logic [7:0]  iCH2;
  logic [7:0]  iGAIN0;
  logic [7:0]  iGAIN1;
  logic [7:0]  iGAIN2;
  logic [15:0] oAUDIO_L;
  logic [15:0] oAUDIO_R;
  logic        oSAMPLE_VALID;
  logic        oBUSY;
  logic        oOVERRUN;

  modport master (
    output iSAMPLE_EN, iCH0, iCH1, iCH2, iGAIN0, iGAIN1, iGAIN2,
    input  oAUDIO_L, oAUDIO_R, oSAMPLE_VALID, oBUSY, oOVERRUN
  );

  modport slave (
    input  iSAMPLE_EN, iCH0, iCH1, iCH2, iGAIN0, iGAIN1, iGAIN2,
    output oAUDIO_L, oAUDIO_R, oSAMPLE_VALID, oBUSY, oOVERRUN
  );
endinterface

// File: rtl/audio_mixer.sv
// Three-channel gain/pan mixer with one shared multiplier, saturating stereo output.
// Optional DC-blocking filter stage enabled by defining AUDIO_MIXER_DCBLOCK_EN.
module audio_mixer #(
  parameter logic [2:0] PAN_L = 3'b111,
  parameter logic [2:0] PAN_R = 3'b111
) (
  input  logic         iCLK,
  input  logic         iRST,
  audio_mixer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    SAT  = 3'd4
`ifdef AUDIO_MIXER_DCBLOCK_EN
    ,DCB = 3'd5
`endif
  } state_e;

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > 24'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -24'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  state_e             state_q, state_d;
  logic [7:0]         ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d;
  logic [7:0]         gain0_q, gain0_d, gain1_q, gain1_d, gain2_q, gain2_d;
  logic signed [19:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [15:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic [7:0]         ch_s;
  logic [7:0]         gain_s;
  logic               pan_l_s;
  logic               pan_r_s;
  logic signed [8:0]  diff_s;
  logic signed [8:0]  gain_ext_s;
  logic signed [17:0] prod_s;
  logic signed [19:0] prod_ext_s;
  logic signed [15:0] sat_l_s;
  logic signed [15:0] sat_r_s;

`ifdef AUDIO_MIXER_DCBLOCK_EN
  logic signed [15:0] x_l_q, x_l_d, x_r_q, x_r_d;
  logic signed [15:0] xp_l_q, xp_l_d, xp_r_q, xp_r_d;
  logic signed [23:0] yp_l_q, yp_l_d, yp_r_q, yp_r_d;
  logic signed [23:0] y_l_s;
  logic signed [23:0] y_r_s;
`endif

  // Operand select for the shared multiplier, one channel per MAC state.
  always_comb begin
    ch_s    = ch0_q;
    gain_s  = gain0_q;
    pan_l_s = 1'b0;
    pan_r_s = 1'b0;
    case (state_q)
      MAC0: begin
        ch_s    = ch0_q;
        gain_s  = gain0_q;
        pan_l_s = PAN_L[0];
        pan_r_s = PAN_R[0];
      end
      MAC1: begin
        ch_s    = ch1_q;
        gain_s  = gain1_q;
        pan_l_s = PAN_L[1];
        pan_r_s = PAN_R[1];
      end
      MAC2: begin
        ch_s    = ch2_q;
        gain_s  = gain2_q;
        pan_l_s = PAN_L[2];
        pan_r_s = PAN_R[2];
      end
      default: begin
        pan_l_s = 1'b0;
        pan_r_s = 1'b0;
      end
    endcase
  end

  assign diff_s     = $signed({1'b0, ch_s} - 9'd128);
  assign gain_ext_s = $signed({1'b0, gain_s});
  assign prod_s     = diff_s * gain_ext_s;
  assign prod_ext_s = {{2{prod_s[17]}}, prod_s};
  // acc*2 is exactly representable in 21 bits, widened to 24 for the clamp.
  assign sat_l_s    = sat16({{3{acc_l_q[19]}}, acc_l_q, 1'b0});
  assign sat_r_s    = sat16({{3{acc_r_q[19]}}, acc_r_q, 1'b0});

`ifdef AUDIO_MIXER_DCBLOCK_EN
  assign y_l_s = {{8{x_l_q[15]}}, x_l_q} - {{8{xp_l_q[15]}}, xp_l_q} + yp_l_q - (yp_l_q >>> 8);
  assign y_r_s = {{8{x_r_q[15]}}, x_r_q} - {{8{xp_r_q[15]}}, xp_r_q} + yp_r_q - (yp_r_q >>> 8);
`endif

  // Next-state, datapath and output computation for the sample FSM.
  always_comb begin
    state_d   = state_q;
    ch0_d     = ch0_q;
    ch1_d     = ch1_q;
    ch2_d     = ch2_q;
    gain0_d   = gain0_q;
    gain1_d   = gain1_q;
    gain2_d   = gain2_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    valid_d   = 1'b0;
    overrun_d = bus.iSAMPLE_EN && (state_q != IDLE);
`ifdef AUDIO_MIXER_DCBLOCK_EN
    x_l_d  = x_l_q;
    x_r_d  = x_r_q;
    xp_l_d = xp_l_q;
    xp_r_d = xp_r_q;
    yp_l_d = yp_l_q;
    yp_r_d = yp_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.iSAMPLE_EN) begin
          ch0_d   = bus.iCH0;
          ch1_d   = bus.iCH1;
          ch2_d   = bus.iCH2;
          gain0_d = bus.iGAIN0;
          gain1_d = bus.iGAIN1;
          gain2_d = bus.iGAIN2;
          acc_l_d = 20'sd0;
          acc_r_d = 20'sd0;
          state_d = MAC0;
        end else begin
          state_d = IDLE;
        end
      end
      MAC0, MAC1, MAC2: begin
        if (pan_l_s) begin
          acc_l_d = acc_l_q + prod_ext_s;
        end else begin
          acc_l_d = acc_l_q;
        end
        if (pan_r_s) begin
          acc_r_d = acc_r_q + prod_ext_s;
        end else begin
          acc_r_d = acc_r_q;
        end
        if (state_q == MAC0) begin
          state_d = MAC1;
        end else if (state_q == MAC1) begin
          state_d = MAC2;
        end else begin
          state_d = SAT;
        end
      end
`ifdef AUDIO_MIXER_DCBLOCK_EN
      SAT: begin
        x_l_d   = sat_l_s;
        x_r_d   = sat_r_s;
        state_d = DCB;
      end
      DCB: begin
        audio_l_d = sat16(y_l_s);
        audio_r_d = sat16(y_r_s);
        xp_l_d    = x_l_q;
        xp_r_d    = x_r_q;
        yp_l_d    = y_l_s;
        yp_r_d    = y_r_s;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
`else
      SAT: begin
        audio_l_d = sat_l_s;
        audio_r_d = sat_r_s;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      ch0_q     <= 8'd0;
      ch1_q     <= 8'd0;
      ch2_q     <= 8'd0;
      gain0_q   <= 8'd0;
      gain1_q   <= 8'd0;
      gain2_q   <= 8'd0;
      acc_l_q   <= 20'sd0;
      acc_r_q   <= 20'sd0;
      audio_l_q <= 16'sd0;
      audio_r_q <= 16'sd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef AUDIO_MIXER_DCBLOCK_EN
      x_l_q     <= 16'sd0;
      x_r_q     <= 16'sd0;
      xp_l_q    <= 16'sd0;
      xp_r_q    <= 16'sd0;
      yp_l_q    <= 24'sd0;
      yp_r_q    <= 24'sd0;
`endif
    end else begin
      state_q   <= state_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      ch2_q     <= ch2_d;
      gain0_q   <= gain0_d;
      gain1_q   <= gain1_d;
      gain2_q   <= gain2_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef AUDIO_MIXER_DCBLOCK_EN
      x_l_q     <= x_l_d;
      x_r_q     <= x_r_d;
      xp_l_q    <= xp_l_d;
      xp_r_q    <= xp_r_d;
      yp_l_q    <= yp_l_d;
      yp_r_q    <= yp_r_d;
`endif
    end
  end

  assign bus.oAUDIO_L      = audio_l_q;
  assign bus.oAUDIO_R      = audio_r_q;
  assign bus.oSAMPLE_VALID = valid_q;
  assign bus.oBUSY         = busy_q;
  assign bus.oOVERRUN      = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed self-checking bench for audio_mixer: default mixer plus a right-pan-limited copy.
module tb_audio_mixer;

  logic iclk = 1'b0;
  logic irst;

  always #5 iclk = ~iclk;

  audio_mixer_if bus_m ();
  audio_mixer_if bus_p ();

  audio_mixer dut_m (
    .iCLK (iclk),
    .iRST (irst),
    .bus  (bus_m.slave)
  );

  audio_mixer #(.PAN_L(3'b111), .PAN_R(3'b001)) dut_p (
    .iCLK (iclk),
    .iRST (irst),
    .bus  (bus_p.slave)
  );

`ifdef AUDIO_MIXER_DCBLOCK_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic set_inputs(input logic [7:0] c0, c1, c2, g0, g1, g2);
    bus_m.iCH0 = c0;  bus_m.iCH1 = c1;  bus_m.iCH2 = c2;
    bus_m.iGAIN0 = g0; bus_m.iGAIN1 = g1; bus_m.iGAIN2 = g2;
    bus_p.iCH0 = c0;  bus_p.iCH1 = c1;  bus_p.iCH2 = c2;
    bus_p.iGAIN0 = g0; bus_p.iGAIN1 = g1; bus_p.iGAIN2 = g2;
  endtask

  task automatic set_en(input logic en);
    bus_m.iSAMPLE_EN = en;
    bus_p.iSAMPLE_EN = en;
  endtask

  // Returns edges from the strobe-sampling edge to the valid pulse, -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge iclk);
      if (bus_m.oSAMPLE_VALID) begin
        lat = i;
        break;
      end
    end
  endtask

  // Strobe one sample, then scramble inputs to prove they were snapshotted.
  task automatic run_sample(input logic [7:0] c0, c1, c2, g0, g1, g2, output int lat);
    set_inputs(c0, c1, c2, g0, g1, g2);
    set_en(1'b1);
    @(negedge iclk);
    set_en(1'b0);
    set_inputs(8'h3C, 8'hC3, 8'h11, 8'd7, 8'd200, 8'd99);
    wait_valid(lat);
  endtask

  int lat;
  int nv;
  int first;
  int val;

  initial begin
    irst = 1'b1;
    set_en(1'b0);
    set_inputs(8'h00, 8'h00, 8'h00, 8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge iclk);
    chk("rst_audio_l", s16(bus_m.oAUDIO_L), 0);
    chk("rst_valid", int'(bus_m.oSAMPLE_VALID), 0);
    chk("rst_busy", int'(bus_m.oBUSY), 0);
    chk("rst_overrun", int'(bus_m.oOVERRUN), 0);
    irst = 1'b0;
    @(negedge iclk);

`ifdef AUDIO_MIXER_DCBLOCK_EN
    run_sample(8'hFF, 8'h80, 8'h80, 8'd128, 8'd0, 8'd0, lat);
    chk("dc1_lat", lat, 5);
    chk("dc1_l", s16(bus_m.oAUDIO_L), 32512);
    chk("dc1_r", s16(bus_m.oAUDIO_R), 32512);
    @(negedge iclk);
    run_sample(8'hFF, 8'h80, 8'h80, 8'd128, 8'd0, 8'd0, lat);
    chk("dc2_lat", lat, 5);
    chk("dc2_l", s16(bus_m.oAUDIO_L), 32385);
    @(negedge iclk);
    run_sample(8'hFF, 8'h80, 8'h80, 8'd128, 8'd0, 8'd0, lat);
    chk("dc3_lat", lat, 5);
    chk("dc3_l", s16(bus_m.oAUDIO_L), 32259);
    chk("dc3_r", s16(bus_m.oAUDIO_R), 32259);
    @(negedge iclk);
`else
    // Unity mix: 127 * 128 * 2.
    run_sample(8'hFF, 8'h80, 8'h80, 8'd128, 8'd0, 8'd0, lat);
    chk("unity_lat", lat, 4);
    chk("unity_l", s16(bus_m.oAUDIO_L), 32512);
    chk("unity_r", s16(bus_m.oAUDIO_R), 32512);
    @(negedge iclk);
    chk("unity_pulse_one_cycle", int'(bus_m.oSAMPLE_VALID), 0);
    chk("unity_hold_l", s16(bus_m.oAUDIO_L), 32512);
    chk("idle_busy", int'(bus_m.oBUSY), 0);

    run_sample(8'hFF, 8'hFF, 8'hFF, 8'd255, 8'd255, 8'd255, lat);
    chk("satpos_lat", lat, 4);
    chk("satpos_l", s16(bus_m.oAUDIO_L), 32767);
    chk("satpos_r", s16(bus_m.oAUDIO_R), 32767);
    @(negedge iclk);

    run_sample(8'h00, 8'h00, 8'h00, 8'd255, 8'd255, 8'd255, lat);
    chk("satneg_lat", lat, 4);
    chk("satneg_l", s16(bus_m.oAUDIO_L), -32768);
    chk("satneg_r", s16(bus_m.oAUDIO_R), -32768);
    @(negedge iclk);

    run_sample(8'h80, 8'hFF, 8'h80, 8'd0, 8'd128, 8'd0, lat);
    chk("pan_lat", lat, 4);
    chk("pan_main_r", s16(bus_m.oAUDIO_R), 32512);
    chk("pan_l", s16(bus_p.oAUDIO_L), 32512);
    chk("pan_r", s16(bus_p.oAUDIO_R), 0);
    @(negedge iclk);

    // Overrun: second strobe two cycles after the first is dropped.
    set_inputs(8'h00, 8'h80, 8'h80, 8'd128, 8'd128, 8'd128);
    set_en(1'b1);
    @(negedge iclk);
    set_en(1'b0);
    chk("ovr_busy", int'(bus_m.oBUSY), 1);
    @(negedge iclk);
    set_inputs(8'hFF, 8'hFF, 8'hFF, 8'd128, 8'd128, 8'd128);
    set_en(1'b1);
    chk("ovr_before", int'(bus_m.oOVERRUN), 0);
    @(negedge iclk);
    set_en(1'b0);
    chk("ovr_pulse", int'(bus_m.oOVERRUN), 1);
    nv = 0;
    first = -1;
    val = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge iclk);
      if (i == 1) chk("ovr_one_cycle", int'(bus_m.oOVERRUN), 0);
      if (bus_m.oSAMPLE_VALID) begin
        nv++;
        if (first < 0) begin
          first = i;
          val = s16(bus_m.oAUDIO_L);
        end
      end
    end
    chk("ovr_valid_count", nv, 1);
    chk("ovr_valid_time", first, 2);
    chk("ovr_data", val, -32768);

    // Back-to-back: new strobe on the cycle valid is high.
    run_sample(8'hFF, 8'h80, 8'h80, 8'd128, 8'd128, 8'd128, lat);
    chk("b2b_a_l", s16(bus_m.oAUDIO_L), 32512);
    set_inputs(8'h00, 8'h80, 8'h80, 8'd128, 8'd128, 8'd128);
    set_en(1'b1);
    @(negedge iclk);
    set_en(1'b0);
    wait_valid(lat);
    chk("b2b_lat", lat, 4);
    chk("b2b_b_l", s16(bus_m.oAUDIO_L), -32768);
    @(negedge iclk);
`endif

    // Reset mid-MAC1 discards the sample; strobe right after release is taken.
    set_inputs(8'hFF, 8'h80, 8'h80, 8'd128, 8'd128, 8'd128);
    set_en(1'b1);
    @(negedge iclk);
    set_en(1'b0);
    @(negedge iclk);
    irst = 1'b1;
    #1;
    chk("midrst_l", s16(bus_m.oAUDIO_L), 0);
    chk("midrst_r", s16(bus_m.oAUDIO_R), 0);
    chk("midrst_busy", int'(bus_m.oBUSY), 0);
    chk("midrst_valid", int'(bus_m.oSAMPLE_VALID), 0);
    chk("midrst_overrun", int'(bus_m.oOVERRUN), 0);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iclk);
      if (bus_m.oSAMPLE_VALID) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    irst = 1'b0;
    run_sample(8'hFF, 8'h80, 8'h80, 8'd128, 8'd0, 8'd0, lat);
    chk("postrst_lat", lat, LAT);
    chk("postrst_l", s16(bus_m.oAUDIO_L), 32512);
    @(negedge iclk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter PAN_L, default 3'b111, meaning per-channel left-bus enable (bit n = channel n).
REQ-002 SHALL have parameter PAN_R, default 3'b111, meaning per-channel right-bus enable.
REQ-003 SHALL have port iCLK  input  1  single core clock; every register clocked on its rising edge.
REQ-004 SHALL have port iRST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port iSAMPLE_EN  input  1  one-cycle strobe requesting a new mixed sample.
REQ-006 SHALL have ports iCH0, iCH1, iCH2  input  8 each  unsigned sound-source samples, midpoint 0x80.
REQ-007 SHALL have ports iGAIN0, iGAIN1, iGAIN2  input  8 each  unsigned gains; 128 = unity.
REQ-008 SHALL have ports oAUDIO_L, oAUDIO_R  output  16 each  signed two's-complement mixed samples, held between updates, feeding the I2S stage.
REQ-009 SHALL have port oSAMPLE_VALID  output  1  one-cycle pulse when oAUDIO_L/R update.
REQ-010 SHALL have port oBUSY  output  1  high while not IDLE.
REQ-011 SHALL have port oOVERRUN  output  1  one-cycle pulse when iSAMPLE_EN is dropped.

Function
REQ-012 SHALL implement FSM IDLE -> MAC0 -> MAC1 -> MAC2 -> SAT -> IDLE (DCB inserted between SAT and IDLE when the macro is defined); each state lasts exactly one cycle.
REQ-013 SHALL, in IDLE with iSAMPLE_EN=1, snapshot all six data inputs and enter MAC0; later input changes do not affect that sample.
REQ-014 SHALL, in MACn, use one shared multiplier: p = (chn - 128) signed 9-bit times gainn unsigned, 18-bit signed product.
REQ-015 SHALL add p to the 20-bit signed left accumulator iff PAN_L[n], right accumulator iff PAN_R[n]; accumulators clear on leaving IDLE.
REQ-016 SHALL, in SAT, compute acc*2 and saturate to [-32768, 32767] per side.
REQ-017 SHALL, without the macro, register saturated values onto oAUDIO_L/R and pulse oSAMPLE_VALID on the SAT->IDLE edge: outputs valid 4 cycles after the strobe-sampling edge.
REQ-018 SHALL, when iSAMPLE_EN=1 in any non-IDLE state, ignore it and pulse oOVERRUN the next cycle; the in-flight sample completes unchanged.
REQ-019 SHALL accept a strobe in IDLE on the same cycle oSAMPLE_VALID is high (back-to-back; minimum strobe spacing 5 cycles, 6 with macro).
REQ-020 SHALL keep oAUDIO_L/R unchanged while no sample completes.

Reset
REQ-021 SHALL, on iRST assertion at any time, including mid-FSM, asynchronously force state IDLE, accumulators, DC-filter history, oAUDIO_L/R=0, oSAMPLE_VALID=0, oBUSY=0, oOVERRUN=0; an in-flight sample is discarded with no valid pulse.
REQ-022 SHALL accept a strobe on the first rising edge after iRST deasserts.

Configuration
REQ-023 SHALL, when AUDIO_MIXER_DCBLOCK_EN is defined, add state DCB computing per side y = x - x_prev + y_prev - (y_prev >>> 8) in 24-bit signed, x = SAT output, then saturate y to 16 bits for output; x_prev/y_prev update only on completed samples; latency 5 cycles.
REQ-024 SHALL, when AUDIO_MIXER_DCBLOCK_EN is undefined, contain no DCB state or filter registers, latency 4 cycles.

Verification
REQ-025 SHALL cover reset: assert iRST mid-MAC1 -> outputs 0, oBUSY 0, no oSAMPLE_VALID pulse; strobe after release accepted.
REQ-026 SHALL cover unity mix: iCH0=0xFF, iGAIN0=128, iCH1=iCH2=0x80 -> oAUDIO_L=oAUDIO_R=32512, valid exactly 4 cycles after strobe.
REQ-027 SHALL cover saturation: all iCH=0xFF, all gains 255 -> 32767; all iCH=0x00, all gains 255 -> -32768.
REQ-028 SHALL cover panning: PAN_R=3'b001, iCH1=0xFF, iGAIN1=128, others centred -> L=32512, R=0.
REQ-029 SHALL cover overrun: strobe at cycles 0 and 2 -> oOVERRUN pulse at cycle 3, single valid pulse with cycle-0 data.
REQ-030 SHALL cover macro on: constant REQ-026 input on successive strobes -> outputs 32512, 32385, 32259, latency 5.
